// File: rtl/data_path.sv
// rtl/data_path.sv - 32-bit bus datapath with a general register file, PC/MAR/MDR/IR, Y/Z ALU staging and HI/LO.
module data_path (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        PCout,
    input  logic        ZHighout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        R4out,
    input  logic        R5out,
    input  logic        R6out,
    input  logic        R7out,
    input  logic        MARin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R4in,
    input  logic        R5in,
    input  logic        R6in,
    input  logic        R7in,
    input  logic        R8in,
    input  logic        R9in,
    input  logic        R10in,
    input  logic        R11in,
    input  logic        R12in,
    input  logic        R13in,
    input  logic        R14in,
    input  logic        R15in,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  NEG,
    input  logic        Cin,
    input  logic [31:0] Mdatain
);
    logic [31:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [31:0] y_q, y_d, hi_q, hi_d, lo_q, lo_d, zhigh_q, zhigh_d, zlow_q, zlow_d;
    logic [31:0] r_q [1:15];
    logic [31:0] r_d [1:15];
    logic [15:1] r_in;
    logic [31:0] bus;
    logic [63:0] alu_z;

    assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in};

    always_comb begin
        bus = '0;
        if (PCout)         bus = pc_q;
        else if (ZHighout) bus = zhigh_q;
        else if (Zlowout)  bus = zlow_q;
        else if (MDRout)   bus = mdr_q;
        else if (R2out)    bus = r_q[2];
        else if (R3out)    bus = r_q[3];
        else if (R4out)    bus = r_q[4];
        else if (R5out)    bus = r_q[5];
        else if (R6out)    bus = r_q[6];
        else if (R7out)    bus = r_q[7];
    end

    logic [4:0]         sh;
    logic [63:0]        dbl, ror_t, rol_t;
    logic signed [31:0] sa, sb;
    logic signed [63:0] sa_ext, sb_ext, prod;
    logic [31:0]        quo, rem;

    always_comb begin
        sh     = bus[4:0];
        dbl    = {y_q, y_q};
        ror_t  = dbl >> sh;
        rol_t  = dbl << sh;
        sa     = y_q;
        sb     = bus;
        sa_ext = {{32{y_q[31]}}, y_q};
        sb_ext = {{32{bus[31]}}, bus};
        prod   = sa_ext * sb_ext;
        // Guard the one signed quotient that overflows so it wraps deterministically.
        if (y_q == 32'h8000_0000 && bus == 32'hFFFF_FFFF) begin
            quo = 32'h8000_0000;
            rem = '0;
        end else begin
            quo = sa / sb;
            rem = sa % sb;
        end
        case (NEG)
            5'b00011: alu_z = {32'h0, y_q + bus + {31'h0, Cin}};
            5'b00100: alu_z = {32'h0, y_q - bus};
            5'b00101: alu_z = {32'h0, y_q & bus};
            5'b00110: alu_z = {32'h0, y_q | bus};
            5'b00111: alu_z = {32'h0, ror_t[31:0]};
            5'b01000: alu_z = {32'h0, rol_t[63:32]};
            5'b01001: alu_z = {32'h0, y_q >> sh};
            5'b01010: alu_z = {32'h0, sa >>> sh};
            5'b01011: alu_z = {32'h0, y_q << sh};
            5'b01111: alu_z = (bus == 32'h0) ? {y_q, 32'hFFFF_FFFF} : {rem, quo};
            5'b10000: alu_z = prod;
            5'b10001: alu_z = {32'h0, 32'h0 - bus};
            5'b10010: alu_z = {32'h0, ~bus};
            default:  alu_z = '0;
        endcase
    end

    always_comb begin
        pc_d    = PCin ? bus : (IncPC ? pc_q + 32'd1 : pc_q);
        ir_d    = IRin  ? bus : ir_q;
        mar_d   = MARin ? bus : mar_q;
        mdr_d   = MDRin ? (Read ? Mdatain : bus) : mdr_q;
        y_d     = Yin   ? bus : y_q;
        hi_d    = HIin  ? bus : hi_q;
        lo_d    = LOin  ? bus : lo_q;
        zhigh_d = ZHighIn ? alu_z[63:32] : zhigh_q;
        zlow_d  = ZLowIn  ? alu_z[31:0]  : zlow_q;
        for (int i = 1; i <= 15; i++) r_d[i] = r_in[i] ? bus : r_q[i];
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            pc_q <= '0; ir_q <= '0; mar_q <= '0; mdr_q <= '0; y_q <= '0;
            hi_q <= '0; lo_q <= '0; zhigh_q <= '0; zlow_q <= '0;
            for (int i = 1; i <= 15; i++) r_q[i] <= '0;
        end else begin
            pc_q <= pc_d; ir_q <= ir_d; mar_q <= mar_d; mdr_q <= mdr_d; y_q <= y_d;
            hi_q <= hi_d; lo_q <= lo_d; zhigh_q <= zhigh_d; zlow_q <= zlow_d;
            for (int i = 1; i <= 15; i++) r_q[i] <= r_d[i];
        end
    end

    // Registers with no bus-drive select are observed only hierarchically.
    logic unused_state;
    assign unused_state = ^{ir_q, hi_q, lo_q, mar_q, r_q[1], r_q[8], r_q[9], r_q[10],
                            r_q[11], r_q[12], r_q[13], r_q[14], r_q[15]};
endmodule

// File: tb/tb_data_path.sv
// tb/tb_data_path.sv - self-checking bench for data_path.
module tb_data_path;
    logic        Clock = 0, Clear = 0;
    logic        PCout, ZHighout, Zlowout, MDRout;
    logic [7:2]  rout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
    logic [15:1] rin;
    logic        IncPC, Read, Cin;
    logic [4:0]  NEG;
    logic [31:0] Mdatain;
    int n_cmp = 0, n_err = 0;

    always #5 Clock = ~Clock;

    data_path dut (
        .Clock(Clock), .Clear(Clear), .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .R2out(rout[2]), .R3out(rout[3]), .R4out(rout[4]), .R5out(rout[5]),
        .R6out(rout[6]), .R7out(rout[7]), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]), .R4in(rin[4]), .R5in(rin[5]),
        .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]),
        .R11in(rin[11]), .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .IncPC(IncPC), .Read(Read), .NEG(NEG), .Cin(Cin), .Mdatain(Mdatain)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic        cin;
        logic [63:0] z;
    } alu_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        {PCout, ZHighout, Zlowout, MDRout} = '0;
        rout = '0; rin = '0;
        {MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn} = '0;
        {IncPC, Read, Cin} = '0;
        NEG = '0;
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1; cyc();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v); MDRout = 1; Yin = 1; cyc();
    endtask

    task automatic load_r(input int idx, input logic [31:0] v);
        load_mdr(v); MDRout = 1; rin[idx] = 1; cyc();
    endtask

    task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
        load_y(a);
        load_mdr(b);
        MDRout = 1; NEG = op; Cin = cin; ZHighIn = 1; ZLowIn = 1; cyc();
    endtask

    // Reference ALU built from signed integer arithmetic on 64-bit values.
    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
        longint sa, sb, q, r;
        logic [31:0] t;
        int n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n = int'(b % 32);
        t = a;
        case (op)
            5'd3:  return {32'h0, 32'(a + b + cin)};
            5'd4:  return {32'h0, 32'(a - b)};
            5'd5:  return {32'h0, a & b};
            5'd6:  return {32'h0, a | b};
            5'd7:  begin for (int i = 0; i < n; i++) t = {t[0], t[31:1]}; return {32'h0, t}; end
            5'd8:  begin for (int i = 0; i < n; i++) t = {t[30:0], t[31]}; return {32'h0, t}; end
            5'd9:  begin for (int i = 0; i < n; i++) t = {1'b0, t[31:1]}; return {32'h0, t}; end
            5'd10: begin for (int i = 0; i < n; i++) t = {t[31], t[31:1]}; return {32'h0, t}; end
            5'd11: begin for (int i = 0; i < n; i++) t = {t[30:0], 1'b0}; return {32'h0, t}; end
            5'd15: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; r = sa - q * sb;
                return {32'(r), 32'(q)};
            end
            5'd16: return 64'(sa * sb);
            5'd17: return {32'h0, 32'(0 - b)};
            5'd18: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    alu_vec_t vecs[$];

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;
        logic        c;
        idle();
        Mdatain = '0;
        vecs = '{
            '{5'b00011, 32'h12, 32'h14, 1'b0, 64'h26},
            '{5'b00011, 32'h12, 32'h14, 1'b1, 64'h27},
            '{5'b00011, 32'hFFFFFFFF, 32'h1, 1'b1, 64'h1},
            '{5'b10000, 32'hFFFFFFFE, 32'h3, 1'b0, 64'hFFFFFFFF_FFFFFFFA},
            '{5'b10000, 32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000},
            '{5'b01111, 32'h14, 32'h6, 1'b0, 64'h2_00000003},
            '{5'b01111, 32'hFFFFFFF9, 32'h2, 1'b0, 64'hFFFFFFFF_FFFFFFFD},
            '{5'b01111, 32'h1234, 32'h0, 1'b0, 64'h1234_FFFFFFFF},
            '{5'b10001, 32'h0, 32'h80000000, 1'b0, 64'h80000000},
            '{5'b10001, 32'h0, 32'h14, 1'b0, 64'hFFFFFFEC},
            '{5'b00100, 32'h5, 32'h7, 1'b0, 64'hFFFFFFFE},
            '{5'b00111, 32'h1, 32'h1, 1'b0, 64'h80000000},
            '{5'b01000, 32'h80000001, 32'h4, 1'b0, 64'h18},
            '{5'b01010, 32'h80000000, 32'h4, 1'b0, 64'hF8000000},
            '{5'b01001, 32'h80000000, 32'd24, 1'b0, 64'h80},
            '{5'b01011, 32'hF, 32'd28, 1'b0, 64'hF0000000},
            '{5'b01011, 32'h1, 32'h21, 1'b0, 64'h2},
            '{5'b00101, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 64'h0F000F00},
            '{5'b00110, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 64'hFF0FFF0F},
            '{5'b10010, 32'h0, 32'h0, 1'b0, 64'hFFFFFFFF},
            '{5'b00000, 32'h5, 32'h5, 1'b1, 64'h0}
        };

        #2;
        check("reset_pc", dut.pc_q, 0);
        check("reset_mdr", dut.mdr_q, 0);
        for (int i = 1; i <= 15; i++) check($sformatf("reset_r%0d", i), dut.r_q[i], 0);
        @(posedge Clock); #1;
        Clear = 1;

        foreach (vecs[i]) begin
            run_alu(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("alu_vec%0d", i), {dut.zhigh_q, dut.zlow_q}, vecs[i].z);
        end

        for (int i = 0; i < 150; i++) begin
            op = (i % 3 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(3, 18));
            a = $urandom; b = $urandom; c = 1'($urandom);
            if (i % 5 == 1) b = 32'($urandom_range(0, 40));
            if (i % 7 == 2) b = 0;
            run_alu(op, a, b, c);
            check($sformatf("alu_rand op=%0d a=%h b=%h", op, a, b),
                  {dut.zhigh_q, dut.zlow_q}, model(op, a, b, c));
        end

        load_mdr(32'h5);
        MDRout = 1; rin[7] = 1; cyc();
        check("mdr_to_r7", dut.r_q[7], 32'h5);

        load_r(3, 32'h14);
        rout[3] = 1; NEG = 5'b10001; ZLowIn = 1; cyc();
        Zlowout = 1; rin[6] = 1; cyc();
        check("neg_to_r6", dut.r_q[6], 32'hFFFFFFEC);

        load_r(2, 32'hAA); load_r(5, 32'h55); load_mdr(32'h77);
        MDRout = 1; rout[2] = 1; rout[5] = 1; rin[1] = 1; cyc();
        check("prio_mdr", dut.r_q[1], 32'h77);
        rout[2] = 1; rout[5] = 1; rin[1] = 1; cyc();
        check("prio_r2", dut.r_q[1], 32'hAA);
        rin[1] = 1; cyc();
        check("bus_idle_zero", dut.r_q[1], 32'h0);

        load_r(4, 32'h9);
        rout[4] = 1; rin[4] = 1; cyc();
        check("self_hold", dut.r_q[4], 32'h9);

        load_mdr(32'h7);
        MDRout = 1; PCin = 1; IncPC = 1; cyc();
        check("pcin_wins", dut.pc_q, 32'h7);
        IncPC = 1; cyc();
        check("pc_inc", dut.pc_q, 32'h8);
        PCout = 1; MARin = 1; IRin = 1; HIin = 1; LOin = 1; cyc();
        check("pc_to_mar", dut.mar_q, 32'h8);
        check("pc_to_ir_hi_lo", {dut.ir_q, dut.hi_q ^ dut.lo_q}, {32'h8, 32'h0});
        load_mdr(32'hFFFFFFFF);
        MDRout = 1; PCin = 1; cyc();
        IncPC = 1; cyc();
        check("pc_wrap", dut.pc_q, 32'h0);
        MDRout = 1; Read = 0; MDRin = 1; rout[6] = 1; cyc();
        check("mdr_from_bus", dut.mdr_q, 32'hFFFFFFFF);

        load_mdr(32'h33);
        MDRout = 1; PCin = 1; rin[6] = 1; cyc();
        load_y(32'h40);
        Clear = 0;
        #1;
        check("clear_async_pc", dut.pc_q, 0);
        check("clear_async_r6", dut.r_q[6], 0);
        check("clear_async_y", dut.y_q, 0);
        load_mdr(32'h99);
        MDRout = 1; PCin = 1; IncPC = 1; rin[6] = 1; cyc();
        check("clear_blocks_pc", dut.pc_q, 0);
        check("clear_blocks_mdr", dut.mdr_q, 0);
        Clear = 1;
        load_mdr(32'h3);
        MDRout = 1; NEG = 5'b00011; ZLowIn = 1; cyc();
        check("post_clear_add", dut.zlow_q, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 SHALL use one clock and one reset; reset is asynchronous and active-low (Clock, Clear).
REQ-002 Clock  in  1  rising-edge clock for all registers.
REQ-003 Clear  in  1  asynchronous active-low clear of all registers.
REQ-004 PCout, ZHighout, Zlowout, MDRout, R2out..R7out  in  1 each  bus-drive selects.
REQ-005 MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn  in  1 each  register load enables.
REQ-006 R1in..R15in  in  1 each  general-register load enables.
REQ-007 IncPC  in  1  PC increment enable.
REQ-008 Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
REQ-009 NEG  in  5  ALU operation code.
REQ-010 Cin  in  1  ALU carry-in, used by ADD only.
REQ-011 Mdatain  in  32  memory read data.
REQ-012 No output ports; all state is internal and probed hierarchically.

Function
REQ-013 SHALL have 32-bit registers R1-R15, PC, IR, MAR, MDR, Y, HI, LO, ZHigh, ZLow, plus a 32-bit bus.
REQ-014 Bus source priority: PC > ZHigh > ZLow > MDR > R2..R7 (ascending); no select asserted drives 0.
REQ-015 Each register loads on the rising Clock edge while its enable is high; otherwise it holds.
REQ-016 MDR loads Mdatain when MDRin=1 and Read=1, and loads bus when MDRin=1 and Read=0.
REQ-017 PC loads bus when PCin=1; else it loads PC+1 when IncPC=1 (PCin wins); it wraps modulo 2^32.
REQ-018 ALU is combinational: A = Y, B = bus, producing 64-bit {Zh, Zl}; ZHigh loads Zh on ZHighIn, ZLow loads Zl on ZLowIn.
REQ-019 Opcodes, with Zh = 0 unless noted:
- 00011 ADD: Zl = A+B+Cin.
- 00100 SUB: Zl = A-B.
- 00101 AND; 00110 OR.
- 00111 ROR; 01000 ROL; 01001 SHR (logical); 01010 SHRA (arithmetic); 01011 SHL. Shift/rotate amount is B[4:0].
- 01111 DIV: signed; Zl = quotient, Zh = remainder (sign of A); divide by 0 gives Zl = FFFFFFFF, Zh = A.
- 10000 MUL: signed 64-bit product in {Zh, Zl}.
- 10001 NEG: Zl = -B (two's complement).
- 10010 NOT: Zl = ~B.
- Any other code: {Zh, Zl} = 0.
REQ-020 Arithmetic wraps modulo 2^32 with no overflow flag; NEG of 80000000 gives 80000000.
REQ-021 Simultaneous bus drive and load of the same register in one cycle SHALL load the pre-edge value (register-to-self is a hold).

Reset
REQ-022 Clear=0 SHALL immediately zero every register (R1-R15, PC, IR, MAR, MDR, Y, HI, LO, ZHigh, ZLow), regardless of Clock.
REQ-023 While Clear=0, all loads and increments SHALL be ignored; normal operation resumes at the first rising edge after Clear=1.
REQ-024 Assertion of Clear mid-sequence SHALL abort any partially completed register-transfer sequence with no residual state.

Verification (Clear=1 unless stated)
REQ-025 Mdatain=5, Read=MDRin=1 for one edge, then MDRout=R7in=1 for one edge -> R7=00000005.
REQ-026 R3=00000014; R3out=1, NEG=10001, ZLowIn=1 for one edge, then Zlowout=R6in=1 for one edge -> R6=FFFFFFEC.
REQ-027 Y=00000012, R3out=1, NEG=00011, Cin=0, ZLowIn=1 -> ZLow=00000026; with Cin=1 -> 00000027.
REQ-028 Y=FFFFFFFE, bus=3, MUL with ZHighIn=ZLowIn=1 -> ZHigh=FFFFFFFF, ZLow=FFFFFFFA; Y=14, bus=6, DIV -> ZLow=3, ZHigh=2.
REQ-029 MDR=7: MDRout=PCin=1 for one edge -> PC=7; then IncPC=1 for one edge -> PC=8; then PCout=MARin=1 for one edge -> MAR=8.
REQ-030 After loading non-zero R6 and PC, drive Clear=0 between edges -> all registers read 0 before the next edge; loads during Clear=0 have no effect.
